// File: rtl/rsc_encoder_pipe.sv
// LTE 8-state RSC constituent encoder (g0 = 1+D^2+D^3, g1 = 1+D+D^3), one bit per cycle.
// Define RSC_TERM_EN to append three trellis-termination tail pairs per block.
module rsc_encoder_pipe #(
  parameter int K_MAX = 6144,
  parameter int CW    = $clog2(K_MAX + 1)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          nClear,
  input  logic          Enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sys,
  output logic          out_par,
  output logic          out_tail,
  output logic          out_last,
  output logic [CW-1:0] blk_len,
  output logic          err_ovf
);

  localparam logic [0:0] ENC  = 1'b0;
`ifdef RSC_TERM_EN
  localparam logic [0:0] TAIL = 1'b1;
`endif

  logic [0:0]    state;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic          reg_free;
  logic          accept;
  logic          blk_end;
  logic          f_in, z_in;

  assign reg_free = !out_valid || out_ready;
  assign in_ready = Enable && (state == ENC) && reg_free;
  assign accept   = in_valid && in_ready;
  assign blk_end  = in_last || (cnt == CW'(K_MAX - 1));
  assign f_in     = in_bit ^ s2 ^ s3;
  assign z_in     = f_in ^ s1 ^ s3;

`ifdef RSC_TERM_EN
  logic [1:0] tcnt;
  logic       tail_step;
  logic       out_tail_r;

  assign tail_step = Enable && (state == TAIL) && reg_free;
  assign out_tail  = out_tail_r;
`else
  assign out_tail  = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= ENC;
      {s1, s2, s3} <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
      blk_len   <= '0;
      err_ovf   <= 1'b0;
`ifdef RSC_TERM_EN
      tcnt       <= '0;
      out_tail_r <= 1'b0;
`endif
    end else if (!nClear) begin
      state     <= ENC;
      {s1, s2, s3} <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
      blk_len   <= '0;
      err_ovf   <= 1'b0;
`ifdef RSC_TERM_EN
      tcnt       <= '0;
      out_tail_r <= 1'b0;
`endif
    end else if (Enable) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_sys   <= in_bit;
        out_par   <= z_in;
        s1        <= f_in;
        s2        <= s1;
        s3        <= s2;
`ifdef RSC_TERM_EN
        out_tail_r <= 1'b0;
`endif
        if (blk_end) begin
          blk_len <= cnt + 1'b1;
          cnt     <= '0;
          // Hitting K_MAX without in_last closes the block anyway and flags it.
          if (!in_last)
            err_ovf <= 1'b1;
`ifdef RSC_TERM_EN
          state    <= TAIL;
          out_last <= 1'b0;
`else
          out_last <= 1'b1;
          {s1, s2, s3} <= '0;
`endif
        end else begin
          cnt      <= cnt + 1'b1;
          out_last <= 1'b0;
        end
      end
`ifdef RSC_TERM_EN
      else if (tail_step) begin
        // Tail input u = s2^s3 cancels the feedback, so f = 0 shifts in.
        out_valid  <= 1'b1;
        out_sys    <= s2 ^ s3;
        out_par    <= s1 ^ s3;
        out_tail_r <= 1'b1;
        s1         <= 1'b0;
        s2         <= s1;
        s3         <= s2;
        if (tcnt == 2'd2) begin
          tcnt     <= '0;
          out_last <= 1'b1;
          state    <= ENC;
        end else begin
          tcnt     <= tcnt + 2'd1;
          out_last <= 1'b0;
        end
      end
`endif
      else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsc_encoder_pipe.sv
// Randomized and directed bench for rsc_encoder_pipe against a polynomial-recurrence model.
// Honours RSC_TERM_EN the same way as the design.
module tb_rsc_encoder_pipe;

  localparam int K  = 8;
  localparam int CW = $clog2(K + 1);

  logic          Clock = 1'b0;
  logic          nReset, nClear, Enable;
  logic          in_valid, in_ready, in_bit, in_last;
  logic          out_valid, out_ready, out_sys, out_par, out_tail, out_last;
  logic [CW-1:0] blk_len;
  logic          err_ovf;

  rsc_encoder_pipe #(.K_MAX(K), .CW(CW)) dut (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sys(out_sys), .out_par(out_par),
    .out_tail(out_tail), .out_last(out_last), .blk_len(blk_len), .err_ovf(err_ovf)
  );

  always #5 Clock = ~Clock;

  // pair = {sys, par, tail, last}
  typedef logic [3:0] pair_t;

  bit    in_q[$];
  bit    last_q[$];
  pair_t exp_q[$];
  pair_t obs_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    viol;
  int    ready_mode;
  int    en_start, en_len;
  bit    gap_mode;
  int    exp_blk_len;
  bit    exp_ovf;

  // Reference: w[n] = u ^ w[n-2] ^ w[n-3] (g0), z = w[n] ^ w[n-1] ^ w[n-3] (g1).
  task automatic model_blocks();
    bit w[$];
    int cnt = 0;
    bit u, f, z, endb;
    exp_q.delete();
    foreach (in_q[i]) begin
      if (cnt == 0) w = '{0, 0, 0};
      u = in_q[i];
      f = u ^ w[w.size()-2] ^ w[w.size()-3];
      z = f ^ w[w.size()-1] ^ w[w.size()-3];
      w.push_back(f);
      cnt++;
      endb = last_q[i] || (cnt == K);
      if (endb && !last_q[i]) exp_ovf = 1'b1;
`ifdef RSC_TERM_EN
      exp_q.push_back({u, z, 1'b0, 1'b0});
      if (endb) begin
        for (int t = 0; t < 3; t++) begin
          u = w[w.size()-2] ^ w[w.size()-3];
          f = u ^ w[w.size()-2] ^ w[w.size()-3];
          z = f ^ w[w.size()-1] ^ w[w.size()-3];
          w.push_back(f);
          exp_q.push_back({u, z, 1'b1, (t == 2)});
        end
      end
`else
      exp_q.push_back({u, z, 1'b0, endb});
`endif
      if (endb) begin
        exp_blk_len = cnt;
        cnt = 0;
      end
    end
  endtask

  task automatic set_inputs(input int c, input int idx);
    Enable = !(c >= en_start && c < en_start + en_len);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    in_valid = (idx < in_q.size()) && (!gap_mode || $urandom_range(0, 3) != 0);
    in_bit   = (idx < in_q.size()) ? in_q[idx] : 1'b0;
    in_last  = (idx < in_q.size()) ? last_q[idx] : 1'b0;
  endtask

  // Streams in_q into the DUT and collects every accepted output pair into obs_q.
  task automatic run_stream(input int budget);
    int    idx = 0;
    int    c = 0;
    bit    acc;
    bit    stalled = 1'b0;
    pair_t prev = '0;
    pair_t cur;
    obs_q.delete();
    viol = 0;
    set_inputs(c, idx);
    while ((idx < in_q.size() || obs_q.size() < exp_q.size()) && c < budget) begin
      @(negedge Clock);
      cur = {out_sys, out_par, out_tail, out_last};
      if (stalled && (!out_valid || cur !== prev)) viol++;
      if (out_valid && !out_ready && in_ready) viol++;
      if (!Enable && in_ready) viol++;
      if (out_valid && out_ready && Enable) obs_q.push_back(cur);
      stalled = out_valid && !(out_ready && Enable);
      prev    = cur;
      acc     = in_valid && in_ready;
      @(posedge Clock);
      #1;
      if (acc) idx++;
      c++;
      set_inputs(c, idx);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    Enable    = 1'b1;
    out_ready = 1'b1;
    en_start  = -1;
    en_len    = 0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; nClear = 1'b1; Enable = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if ({out_valid, out_sys, out_par, out_tail, out_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=00000", {out_valid, out_sys, out_par, out_tail, out_last});
    end
    n_checks++;
    if (blk_len !== '0 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status blk_len=%0d err_ovf=%b want 0/0", blk_len, err_ovf);
    end
    nReset = 1'b1;
    @(posedge Clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    pair_t gold[$];
    in_q   = '{1, 0, 0, 0, 1, 1};
    last_q = '{0, 0, 0, 1, 0, 1};
`ifdef RSC_TERM_EN
    gold = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b0110, 4'b1111,
             4'b1100, 4'b1000, 4'b1110, 4'b0110, 4'b1111};
`else
    gold = '{4'b1100, 4'b0100, 4'b0100, 4'b0101, 4'b1100, 4'b1001};
`endif
    model_blocks();
    ready_mode = 0; gap_mode = 1'b0;
    run_stream(200);
    n_checks++;
    if (obs_q.size() != gold.size()) begin
      n_fail++;
      $display("FAIL directed_count got=%0d want=%0d", obs_q.size(), gold.size());
    end
    for (int i = 0; i < gold.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== gold[i]) begin
        n_fail++;
        $display("FAIL directed_pair[%0d] got=%b want=%b", i, obs_q[i], gold[i]);
      end
    end
    n_checks++;
    if (blk_len !== CW'(2)) begin
      n_fail++;
      $display("FAIL directed_blk_len got=%0d want=2", blk_len);
    end
  endtask

  task automatic test_random();
    int len;
    in_q.delete(); last_q.delete();
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(1, K);
      for (int i = 0; i < len; i++) begin
        in_q.push_back(1'($urandom_range(0, 1)));
        last_q.push_back(i == len - 1);
      end
    end
    model_blocks();
    ready_mode = 2; gap_mode = 1'b1;
    run_stream(2000);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_pair[%0d] got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (blk_len !== CW'(exp_blk_len) || viol != 0) begin
      n_fail++;
      $display("FAIL random_status blk_len=%0d want=%0d handshake_violations=%0d want=0", blk_len, exp_blk_len, viol);
    end
  endtask

  task automatic test_backpressure();
    in_q   = '{1, 1, 0, 1, 0, 0, 1, 1};
    last_q = '{0, 0, 0, 0, 0, 0, 0, 1};
    model_blocks();
    ready_mode = 1; gap_mode = 1'b0;
    run_stream(500);
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL backpressure_stall violations got=%0d want=0", viol);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL backpressure_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL backpressure_pair[%0d] got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    in_q   = '{0, 1, 1, 0, 1, 0, 1, 0};
    last_q = '{0, 0, 0, 0, 0, 0, 0, 1};
    model_blocks();
    ready_mode = 0; gap_mode = 1'b0;
    en_start = 3; en_len = 5;
    run_stream(500);
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL enable_hold violations got=%0d want=0", viol);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL enable_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL enable_pair[%0d] got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    in_q.delete(); last_q.delete();
    for (int i = 0; i < K; i++) begin
      in_q.push_back(1'($urandom_range(0, 1)));
      last_q.push_back(1'b0);
    end
    model_blocks();
    ready_mode = 0; gap_mode = 1'b0;
    run_stream(500);
    n_checks++;
    if (err_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag got=%b want=1", err_ovf);
    end
    n_checks++;
    if (blk_len !== CW'(K)) begin
      n_fail++;
      $display("FAIL overflow_blk_len got=%0d want=%0d", blk_len, K);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL overflow_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overflow_pair[%0d] got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit ab_bits[3];
    ab_bits = '{1, 1, 0};
    // Feed three bits of what would be a six-bit block, then clear.
    Enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = ab_bits[i]; in_last = 1'b0;
      @(posedge Clock);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_valid got=%b want=1", out_valid);
    end
    nClear = 1'b0;
    @(posedge Clock);
    #1;
    nClear = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || err_ovf !== 1'b0 || blk_len !== '0) begin
      n_fail++;
      $display("FAIL abort_clear valid=%b err_ovf=%b blk_len=%0d want 0/0/0", out_valid, err_ovf, blk_len);
    end
    exp_ovf = 1'b0;
`ifdef RSC_TERM_EN
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
    @(posedge Clock);
    #1;
    in_bit = 1'b0; in_last = 1'b1;
    @(posedge Clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 20 && !out_tail; i++) @(negedge Clock);
    n_checks++;
    if (out_tail !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_tail_reach out_tail=%b want=1", out_tail);
    end
    nReset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_tail !== 1'b0 || blk_len !== '0) begin
      n_fail++;
      $display("FAIL abort_tail_reset valid=%b tail=%b blk_len=%0d want 0/0/0", out_valid, out_tail, blk_len);
    end
    @(posedge Clock);
    #1;
    nReset = 1'b1;
`endif
    in_q   = '{1, 0, 1, 1, 0, 1};
    last_q = '{0, 0, 0, 0, 0, 1};
    model_blocks();
    ready_mode = 0; gap_mode = 1'b0;
    run_stream(300);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL abort_next_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_next_pair[%0d] got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (blk_len !== CW'(6) || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_status blk_len=%0d err_ovf=%b want 6/0", blk_len, err_ovf);
    end
  endtask

  initial begin
    en_start = -1; en_len = 0; exp_ovf = 1'b0; exp_blk_len = 0;
    ready_mode = 0; gap_mode = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_enable_gating();
    test_overflow();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
